writeback: RTL and testbench
============================

# writeback

Final commit stage of the CPU: accepts one bundle of execution results per instruction and applies it to the architectural state. That state is the 8-entry register file, the status register, the program counter and the data-memory write port. It handshakes the memory write to completion, then pulses `wb_done` to start the next fetch. It also serves the operand read ports consumed by execute.

## Interface
Parameters:
- `WORD`, 16, datapath width; matches `` `WORD `` in fmt.v
- `NREGS`, 8, register count; 3-bit register codes
- `RESET_PC`, 0, PC value after reset

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `ex_valid`  in  1  one-cycle pulse; result bundle below is valid
- `reg_wb`  in  1  write register file
- `reg_write_code`  in  3  destination register
- `reg_write_val`  in  WORD  register write data
- `mem_wb`  in  1  write data memory
- `mem_write_addr`  in  WORD  memory address
- `mem_write_val`  in  WORD  memory data
- `flag_update`  in  1  load status register
- `SREG_in`  in  WORD  new status value
- `jump`  in  1  absolute PC load
- `PC_jump_loc`  in  WORD  absolute target
- `PC_jump_inc`  in  WORD  relative PC increment
- `rd1_code`, `rd2_code`  in  3  operand read selects
- `rd1_data`, `rd2_data`  out  WORD  operand read data, combinational
- `SREG`  out  WORD  status register
- `PC`  out  WORD  program counter
- `mem_we`  out  1  memory write request
- `mem_addr`, `mem_wdata`  out  WORD  memory write address/data
- `mem_ack`  in  1  memory write accepted
- `wb_done`  out  1  one-cycle completion pulse
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, COMMIT, MEM_WAIT, DONE.
- IDLE: when `ex_valid`=1, capture every bundle input into holding registers and go to COMMIT. `ex_valid` is ignored in all other states; the bundle is dropped and no state changes.
- COMMIT, single edge:
  - if `reg_wb`, write `reg_write_val` to the register selected by `reg_write_code`; all 8 registers are writable.
  - if `flag_update`, SREG is loaded from `SREG_in`; otherwise SREG holds.
  - PC is loaded from `PC_jump_loc` if `jump`, else becomes PC+`PC_jump_inc` modulo 2^WORD.
  - next state is MEM_WAIT if `mem_wb`, else DONE.
- MEM_WAIT: `mem_we`=1, with `mem_addr`/`mem_wdata` driven from the holding registers and stable. Leaves for DONE on the first edge that samples `mem_ack`=1, with no timeout.
- DONE: `wb_done`=1 for exactly one cycle, then IDLE.
- Read ports return current array contents. There is no bypass from the holding registers.
- Reset values: all registers 0, SREG 0, PC=`RESET_PC`, `mem_we`/`wb_done`/`busy` 0, state IDLE, holding registers 0.
- Reset mid-operation abandons the bundle. `mem_we` falls asynchronously with `rst_n`.

## Timing
- `ex_valid` sampled at edge N. Register, SREG and PC are updated at edge N+1.
- Without a memory write, `wb_done` is high during cycle N+2 (between edges N+2 and N+3). Minimum issue interval is 3 cycles.
- With a memory write, `mem_we` is high from after edge N+2 until the edge M that samples `mem_ack`. `wb_done` is high in the cycle after M. An `mem_ack` already high at the first MEM_WAIT edge gives a 1-cycle request.
- Register, flag and PC commits never wait on memory.
- Reads in the cycle before edge N+1 return old values.

## Structure
- fmt.v gains the `WB_*` state encodings. `` `WORD `` and the flag bit positions (`Zf`, `Cf`, `Nf`, `If`) stay there.
- One sub-module, `regfile`: NREGS×WORD, one synchronous write port, two combinational read ports, async reset to 0.

## Test plan
- Reset with `RESET_PC`=0x0100 → PC=0x0100, SREG=0, all registers 0, `mem_we`=0, `busy`=0.
- PC=0x0010, bundle `reg_wb`=1, code 3, value 0x1234, inc 1 → r3=0x1234 and PC=0x0011 at N+1. `wb_done` high only in cycle N+2; `rd1_code`=3 reads 0x1234.
- Jump and wrap:
  - `jump`=1, loc 0x0040 → PC=0x0040.
  - Then PC=0xFFFF, inc 2 → PC=0x0001.
- `mem_wb`, addr 0x0080, data 0xBEEF, `mem_ack` raised 3 cycles into MEM_WAIT → `mem_we` high 4 cycles with stable addr/data; `wb_done` pulses once afterwards.
- `flag_update`=1 with `SREG_in`=0x0001 → SREG=0x0001. A following bundle with `flag_update`=0 and `SREG_in`=0xFFFF → SREG stays 0x0001.
- Protocol and reset boundaries:
  - Second `ex_valid` during MEM_WAIT → ignored, exactly one `wb_done`.
  - `rst_n` low during MEM_WAIT → `mem_we` drops in the same cycle, PC=`RESET_PC`, state IDLE.

Source files
------------

// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback commit stage: default sizes and FSM state encodings.
package writeback_pkg;

   localparam int WB_WORD  = 16;
   localparam int WB_NREGS = 8;

   typedef enum logic [1:0] {
      WB_IDLE     = 2'd0,
      WB_COMMIT   = 2'd1,
      WB_MEM_WAIT = 2'd2,
      WB_DONE     = 2'd3
   } wb_state_t;

endpackage

// File: rtl/writeback_regfile.sv
// Architectural register file: one synchronous write port, two combinational read ports.
module writeback_regfile #(
   parameter int WORD  = 16,
   parameter int NREGS = 8,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [WORD-1:0] wdata,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [WORD-1:0] rdata1,
   output logic [WORD-1:0] rdata2
);

   logic [WORD-1:0] regs_reg [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (we) begin
         regs_reg[waddr] <= wdata;
      end
   end

   assign rdata1 = regs_reg[raddr1];
   assign rdata2 = regs_reg[raddr2];

endmodule

// File: rtl/writeback.sv
// Final commit stage: latches one result bundle, commits register/SREG/PC, handshakes the
// optional memory write, then pulses wb_done.
module writeback
   import writeback_pkg::*;
#(
   parameter int          WORD     = WB_WORD,
   parameter int          NREGS    = WB_NREGS,
   parameter int unsigned RESET_PC = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ex_valid,
   input  logic                     reg_wb,
   input  logic [$clog2(NREGS)-1:0] reg_write_code,
   input  logic [WORD-1:0]          reg_write_val,
   input  logic                     mem_wb,
   input  logic [WORD-1:0]          mem_write_addr,
   input  logic [WORD-1:0]          mem_write_val,
   input  logic                     flag_update,
   input  logic [WORD-1:0]          SREG_in,
   input  logic                     jump,
   input  logic [WORD-1:0]          PC_jump_loc,
   input  logic [WORD-1:0]          PC_jump_inc,
   input  logic [$clog2(NREGS)-1:0] rd1_code,
   input  logic [$clog2(NREGS)-1:0] rd2_code,
   output logic [WORD-1:0]          rd1_data,
   output logic [WORD-1:0]          rd2_data,
   output logic [WORD-1:0]          SREG,
   output logic [WORD-1:0]          PC,
   output logic                     mem_we,
   output logic [WORD-1:0]          mem_addr,
   output logic [WORD-1:0]          mem_wdata,
   input  logic                     mem_ack,
   output logic                     wb_done,
   output logic                     busy
);

   localparam int AW = $clog2(NREGS);

   wb_state_t       state_reg, state_next;
   logic            commit_done_reg;
   logic            commit_edge;

   logic            hold_reg_wb_reg;
   logic [AW-1:0]   hold_code_reg;
   logic [WORD-1:0] hold_reg_val_reg;
   logic            hold_mem_wb_reg;
   logic [WORD-1:0] hold_mem_addr_reg;
   logic [WORD-1:0] hold_mem_val_reg;
   logic            hold_flag_reg;
   logic [WORD-1:0] hold_sreg_reg;
   logic            hold_jump_reg;
   logic [WORD-1:0] hold_loc_reg;
   logic [WORD-1:0] hold_inc_reg;

   logic [WORD-1:0] sreg_reg;
   logic [WORD-1:0] pc_reg;

   // COMMIT spends its first edge writing state and its second edge choosing the exit,
   // which places wb_done / mem_we two edges after the commit edge.
   assign commit_edge = (state_reg == WB_COMMIT) && !commit_done_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= WB_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         WB_IDLE:     if (ex_valid) state_next = WB_COMMIT;
         WB_COMMIT:   if (commit_done_reg) state_next = hold_mem_wb_reg ? WB_MEM_WAIT : WB_DONE;
         WB_MEM_WAIT: if (mem_ack) state_next = WB_DONE;
         WB_DONE:     state_next = WB_IDLE;
         default:     state_next = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_done_reg   <= 1'b0;
         hold_reg_wb_reg   <= 1'b0;
         hold_code_reg     <= '0;
         hold_reg_val_reg  <= '0;
         hold_mem_wb_reg   <= 1'b0;
         hold_mem_addr_reg <= '0;
         hold_mem_val_reg  <= '0;
         hold_flag_reg     <= 1'b0;
         hold_sreg_reg     <= '0;
         hold_jump_reg     <= 1'b0;
         hold_loc_reg      <= '0;
         hold_inc_reg      <= '0;
         sreg_reg          <= '0;
         pc_reg            <= WORD'(RESET_PC);
      end else begin
         if (state_reg == WB_IDLE && ex_valid) begin
            hold_reg_wb_reg   <= reg_wb;
            hold_code_reg     <= reg_write_code;
            hold_reg_val_reg  <= reg_write_val;
            hold_mem_wb_reg   <= mem_wb;
            hold_mem_addr_reg <= mem_write_addr;
            hold_mem_val_reg  <= mem_write_val;
            hold_flag_reg     <= flag_update;
            hold_sreg_reg     <= SREG_in;
            hold_jump_reg     <= jump;
            hold_loc_reg      <= PC_jump_loc;
            hold_inc_reg      <= PC_jump_inc;
         end
         if (commit_edge) begin
            commit_done_reg <= 1'b1;
            if (hold_flag_reg) begin
               sreg_reg <= hold_sreg_reg;
            end
            pc_reg <= hold_jump_reg ? hold_loc_reg : pc_reg + hold_inc_reg;
         end else if (state_reg == WB_COMMIT) begin
            commit_done_reg <= 1'b0;
         end
      end
   end

   writeback_regfile #(
      .WORD  (WORD),
      .NREGS (NREGS),
      .AW    (AW)
   ) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (commit_edge && hold_reg_wb_reg),
      .waddr  (hold_code_reg),
      .wdata  (hold_reg_val_reg),
      .raddr1 (rd1_code),
      .raddr2 (rd2_code),
      .rdata1 (rd1_data),
      .rdata2 (rd2_data)
   );

   // Decoded straight from the state register so mem_we drops together with rst_n.
   assign mem_we    = (state_reg == WB_MEM_WAIT);
   assign wb_done   = (state_reg == WB_DONE);
   assign busy      = (state_reg != WB_IDLE);
   assign mem_addr  = hold_mem_addr_reg;
   assign mem_wdata = hold_mem_val_reg;
   assign SREG      = sreg_reg;
   assign PC        = pc_reg;

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: each issued bundle pushes its expected commit, the
// wb_done monitor pops and compares.
module tb_writeback;

   localparam logic [15:0] RST_PC = 16'h0100;

   typedef struct {
      logic        rwb;
      logic [2:0]  code;
      logic [15:0] rval;
      logic        mwb;
      logic [15:0] addr;
      logic [15:0] data;
      logic        fu;
      logic [15:0] sin;
      logic        jmp;
      logic [15:0] loc;
      logic [15:0] inc;
   } bundle_t;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] sreg;
      logic [2:0]  code;
      logic [15:0] rval;
      logic [15:0] addr;
      logic [15:0] data;
      int          mem_cycles;
   } exp_t;

   logic        clk, rst_n, ex_valid, reg_wb, mem_wb, flag_update, jump, mem_ack;
   logic [2:0]  reg_write_code, rd1_code, rd2_code;
   logic [15:0] reg_write_val, mem_write_addr, mem_write_val, SREG_in, PC_jump_loc, PC_jump_inc;
   logic [15:0] rd1_data, rd2_data, SREG, PC, mem_addr, mem_wdata;
   logic        mem_we, wb_done, busy;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int issued = 0;
   int mem_cnt = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   logic [15:0] mdl_pc, mdl_sreg;
   logic [15:0] mdl_regs [8];

   writeback #(.WORD(16), .NREGS(8), .RESET_PC(32'h0100)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .reg_wb(reg_wb),
      .reg_write_code(reg_write_code), .reg_write_val(reg_write_val),
      .mem_wb(mem_wb), .mem_write_addr(mem_write_addr), .mem_write_val(mem_write_val),
      .flag_update(flag_update), .SREG_in(SREG_in), .jump(jump),
      .PC_jump_loc(PC_jump_loc), .PC_jump_inc(PC_jump_inc),
      .rd1_code(rd1_code), .rd2_code(rd2_code), .rd1_data(rd1_data), .rd2_data(rd2_data),
      .SREG(SREG), .PC(PC), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .wb_done(wb_done), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic bundle_t mk(input logic rwb, input logic [2:0] code, input logic [15:0] rval,
                                  input logic mwb, input logic [15:0] addr, input logic [15:0] data,
                                  input logic fu, input logic [15:0] sin, input logic jmp,
                                  input logic [15:0] loc, input logic [15:0] inc);
      bundle_t b;
      b.rwb = rwb; b.code = code; b.rval = rval; b.mwb = mwb; b.addr = addr; b.data = data;
      b.fu = fu; b.sin = sin; b.jmp = jmp; b.loc = loc; b.inc = inc;
      return b;
   endfunction

   task automatic drive_bundle(input bundle_t b);
      reg_wb = b.rwb; reg_write_code = b.code; reg_write_val = b.rval;
      mem_wb = b.mwb; mem_write_addr = b.addr; mem_write_val = b.data;
      flag_update = b.fu; SREG_in = b.sin; jump = b.jmp; PC_jump_loc = b.loc; PC_jump_inc = b.inc;
   endtask

   function automatic bundle_t rnd_bundle();
      return mk(1'($urandom), 3'($urandom), 16'($urandom), 1'($urandom), 16'($urandom),
                16'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom),
                16'($urandom));
   endfunction

   task automatic model_reset();
      mdl_pc = RST_PC;
      mdl_sreg = '0;
      for (int i = 0; i < 8; i++) mdl_regs[i] = '0;
   endtask

   // Issue one bundle and follow it through to idle; extra pulses ex_valid during MEM_WAIT.
   task automatic send(input bundle_t b, input int ack_delay, input bit extra);
      exp_t e;
      logic [15:0] old_pc, old_reg;
      int n;
      bit left;
      old_pc = mdl_pc;
      old_reg = mdl_regs[b.code];
      mdl_pc = b.jmp ? b.loc : mdl_pc + b.inc;
      if (b.fu) mdl_sreg = b.sin;
      if (b.rwb) mdl_regs[b.code] = b.rval;
      e.pc = mdl_pc; e.sreg = mdl_sreg; e.code = b.code; e.rval = mdl_regs[b.code];
      e.addr = b.addr; e.data = b.data; e.mem_cycles = b.mwb ? ack_delay + 1 : 0;
      sb_q.push_back(e);
      issued++;
      $display("txn %0d: rwb=%0d r%0d=%h mwb=%0d [%h]=%h fu=%0d sin=%h jmp=%0d loc=%h inc=%h ack_delay=%0d",
               issued, b.rwb, b.code, b.rval, b.mwb, b.addr, b.data, b.fu, b.sin, b.jmp, b.loc,
               b.inc, ack_delay);

      @(posedge clk); #1;
      drive_bundle(b);
      ex_valid = 1'b1;
      rd1_code = b.code;
      @(posedge clk); #1;          // edge N
      ex_valid = 1'b0;
      drive_bundle(rnd_bundle());
      @(negedge clk);
      check_val("pc_before_commit", PC, old_pc);
      check_val("reg_before_commit", rd1_data, old_reg);
      check_val("busy_in_commit", busy, 1);
      @(negedge clk);              // after edge N+1
      check_val("pc_at_n1", PC, e.pc);
      check_val("sreg_at_n1", SREG, e.sreg);
      check_val("reg_at_n1", rd1_data, e.rval);
      check_val("done_low_n1", wb_done, 0);
      @(negedge clk);              // cycle N+2
      if (!b.mwb) begin
         check_val("done_at_n2", wb_done, 1);
         check_val("mem_we_low", mem_we, 0);
      end else begin
         check_val("mem_we_at_n2", mem_we, 1);
         n = 0;
         left = 0;
         for (int k = 0; k < 64; k++) begin
            if (mem_we) begin
               n++;
               mem_ack = (n > ack_delay);
               if (extra && n == 2) begin
                  drive_bundle(mk(1, 3'd5, 16'hDEAD, 1, 16'h9999, 16'h9999, 1, 16'hFFFF, 1,
                                  16'h7777, 16'h0000));
                  ex_valid = 1'b1;
               end else begin
                  ex_valid = 1'b0;
               end
            end else begin
               mem_ack = 1'b0;
               ex_valid = 1'b0;
               left = 1;
               break;
            end
            @(negedge clk);
         end
         if (!left) check_val("mem_ack_timeout", 1, 0);
         check_val("done_after_ack", wb_done, 1);
      end
      @(negedge clk);
      check_val("idle_after_done", busy, 0);
      check_val("done_one_cycle", wb_done, 0);
   endtask

   // wb_done monitor: pops the scoreboard and compares the committed state.
   always @(negedge clk) begin
      if (!rst_n) begin
         mem_cnt = 0;
      end else begin
         if (mem_we) begin
            mem_cnt++;
            if (sb_q.size() > 0) begin
               check_val("mem_addr", mem_addr, sb_q[0].addr);
               check_val("mem_wdata", mem_wdata, sb_q[0].data);
            end
         end
         if (wb_done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
               check_val("done_unexpected", 1, 0);
            end else begin
               mon_e = sb_q.pop_front();
               check_val("sb_pc", PC, mon_e.pc);
               check_val("sb_sreg", SREG, mon_e.sreg);
               check_val("sb_mem_cycles", mem_cnt, mon_e.mem_cycles);
               rd2_code = mon_e.code;
               #1;
               check_val("sb_reg", rd2_data, mon_e.rval);
            end
            mem_cnt = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit left;
      rst_n = 1'b0; ex_valid = 1'b0; mem_ack = 1'b0; rd1_code = '0; rd2_code = '0;
      drive_bundle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      model_reset();
      repeat (3) @(negedge clk);
      check_val("rst_pc", PC, RST_PC);
      check_val("rst_sreg", SREG, 0);
      check_val("rst_mem_we", mem_we, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", wb_done, 0);
      for (int i = 0; i < 8; i++) begin
         rd1_code = 3'(i);
         #1;
         check_val($sformatf("rst_r%0d", i), rd1_data, 0);
      end
      rst_n = 1'b1;

      send(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0010, 0), 0, 0);
      send(mk(1, 3, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 16'h0001), 0, 0);
      send(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0040, 0), 0, 0);
      send(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFF, 0), 0, 0);
      send(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0002), 0, 0);
      send(mk(1, 7, 16'hA5A5, 1, 16'h0080, 16'hBEEF, 0, 0, 0, 0, 16'h0001), 3, 0);
      send(mk(0, 0, 0, 0, 0, 0, 1, 16'h0001, 0, 0, 16'h0001), 0, 0);
      send(mk(1, 0, 16'h55AA, 0, 0, 0, 0, 16'hFFFF, 0, 0, 16'h0004), 0, 0);
      send(mk(0, 0, 0, 1, 16'h0100, 16'hCAFE, 0, 0, 0, 0, 16'h0001), 0, 0);
      send(mk(1, 1, 16'h0F0F, 1, 16'h0200, 16'h1357, 0, 0, 0, 0, 16'h0003), 4, 1);
      send(mk(1, 5, 16'h0505, 0, 0, 0, 0, 0, 0, 0, 16'h0001), 0, 0);
      for (int t = 0; t < 8; t++) begin
         send(rnd_bundle(), int'($urandom_range(0, 3)), 0);
      end

      // Reset while the memory write is outstanding.
      $display("txn reset-abandon: mem write to 0x0300 with no ack");
      @(posedge clk); #1;
      drive_bundle(mk(1, 2, 16'h4444, 1, 16'h0300, 16'h7E7E, 1, 16'h00F0, 1, 16'h2222, 0));
      ex_valid = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      left = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (mem_we) begin
            left = 1;
            break;
         end
      end
      check_val("abandon_mem_we_seen", left, 1);
      rst_n = 1'b0;
      #1;
      check_val("abandon_mem_we_drop", mem_we, 0);
      check_val("abandon_busy", busy, 0);
      check_val("abandon_pc", PC, RST_PC);
      check_val("abandon_sreg", SREG, 0);
      rd1_code = 3'd2;
      #1;
      check_val("abandon_r2", rd1_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      send(mk(1, 6, 16'h6060, 0, 0, 0, 0, 0, 0, 0, 16'h0005), 0, 0);

      repeat (3) @(negedge clk);
      check_val("done_count", done_cnt, issued);
      check_val("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
